// File: rtl/dual_port_ram_pkg.sv
// -----------------------------------------------------------------------------
// dual_port_ram_pkg
// Shared constants and types for the true dual-port RAM.
//   DEFAULT_DATA_WIDTH : default word width (bits)
//   DEFAULT_ADDR_WIDTH : default address width (depth = 2**ADDR_WIDTH)
//   word_t             : one memory word at the default width
// -----------------------------------------------------------------------------
package dual_port_ram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

endpackage : dual_port_ram_pkg

// File: rtl/dual_port_ram_port_reg.sv
// -----------------------------------------------------------------------------
// dual_port_ram_port_reg
// Registered read-data stage for one RAM port. Captures the word read from
// the array every cycle and clears to zero on reset.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   rd_word  : word read combinationally from the storage array
//   data_out : registered read data
// -----------------------------------------------------------------------------
module dual_port_ram_port_reg
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rd_word,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] dout_d;
    logic [DATA_WIDTH-1:0] dout_q;

    always_comb begin
        dout_d = rd_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign data_out = dout_q;

endmodule : dual_port_ram_port_reg

// File: rtl/dual_port_ram.sv
// -----------------------------------------------------------------------------
// dual_port_ram
// True dual-port synchronous RAM: two independent read/write ports sharing
// one storage array and one clock. Reads are registered (1-cycle latency)
// and read-first; on a same-address double write port A wins.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (clears array and outputs)
//   addr_a     : port A word address
//   data_in_a  : port A write data
//   we_a       : port A write enable
//   data_out_a : port A registered read data
//   addr_b     : port B word address
//   data_in_b  : port B write data
//   we_b       : port B write enable
//   data_out_b : port B registered read data
// -----------------------------------------------------------------------------
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_in_a,
    input  logic                  we_a,
    output logic [DATA_WIDTH-1:0] data_out_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_in_b,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] data_out_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word_a;
    logic [DATA_WIDTH-1:0] rd_word_b;

    // Reads come from the current (pre-write) contents, which makes both
    // same-port and cross-port read-during-write return the old word.
    always_comb begin
        rd_word_a = mem_q[addr_a];
        rd_word_b = mem_q[addr_b];
    end

    // Port B is applied first so that port A overwrites it when both ports
    // target the same address in the same cycle.
    always_comb begin
        mem_d = mem_q;
        if (we_b) begin
            mem_d[addr_b] = data_in_b;
        end
        if (we_a) begin
            mem_d[addr_a] = data_in_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    dual_port_ram_port_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_port_reg_a (
        .clk      (clk),
        .rst      (rst),
        .rd_word  (rd_word_a),
        .data_out (data_out_a)
    );

    dual_port_ram_port_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_port_reg_b (
        .clk      (clk),
        .rst      (rst),
        .rd_word  (rd_word_b),
        .data_out (data_out_b)
    );

endmodule : dual_port_ram

// File: tb/tb_dual_port_ram.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram
// Self-checking bench for dual_port_ram: a directed vector table, a short
// hand-written back-to-back write sequence, and a randomized run compared
// against a simple array model of the memory.
// -----------------------------------------------------------------------------
module tb_dual_port_ram;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] data_in_a;
    logic          we_a;
    logic [DW-1:0] data_out_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] data_in_b;
    logic          we_b;
    logic [DW-1:0] data_out_b;

    int checks   = 0;
    int failures = 0;

    dual_port_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_a     (addr_a),
        .data_in_a  (data_in_a),
        .we_a       (we_a),
        .data_out_a (data_out_a),
        .addr_b     (addr_b),
        .data_in_b  (data_in_b),
        .we_b       (we_b),
        .data_out_b (data_out_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          we_a;
        logic [AW-1:0] addr_a;
        logic [DW-1:0] din_a;
        logic          we_b;
        logic [AW-1:0] addr_b;
        logic [DW-1:0] din_b;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    vec_t vecs [15];

    // Reference memory: plain array updated from the behavioural rules.
    logic [DW-1:0] model [DEPTH];

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Present one cycle of inputs, clock once, sample 1 time unit later.
    task automatic step(input logic r, input logic wa, input logic [AW-1:0] aa,
                        input logic [DW-1:0] da, input logic wb,
                        input logic [AW-1:0] ab, input logic [DW-1:0] db);
        rst       = r;
        we_a      = wa;
        addr_a    = aa;
        data_in_a = da;
        we_b      = wb;
        addr_b    = ab;
        data_in_b = db;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        logic          r;
        logic          wa;
        logic          wb;
        logic [AW-1:0] aa;
        logic [AW-1:0] ab;
        logic [DW-1:0] da;
        logic [DW-1:0] db;

        rst = 1'b1; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0; addr_b = '0; data_in_a = '0; data_in_b = '0;

        //          rst  wa  aa  din_a  wb  ab  din_b  exp_a  exp_b
        vecs[0]  = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{0, 0, 4, 8'h00, 0, 4, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{0, 1, 4, 8'hA5, 0, 4, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{0, 0, 4, 8'h00, 0, 4, 8'h00, 8'hA5, 8'hA5};
        vecs[5]  = '{0, 0, 4, 8'h00, 1, 4, 8'h5A, 8'hA5, 8'hA5};
        vecs[6]  = '{0, 0, 4, 8'h00, 0, 4, 8'h00, 8'h5A, 8'h5A};
        vecs[7]  = '{0, 1, 4, 8'h3C, 0, 4, 8'h00, 8'h5A, 8'h5A};
        vecs[8]  = '{0, 0, 4, 8'h00, 0, 4, 8'h00, 8'h3C, 8'h3C};
        vecs[9]  = '{0, 1, 7, 8'h11, 1, 7, 8'h22, 8'h00, 8'h00};
        vecs[10] = '{0, 0, 7, 8'h00, 0, 7, 8'h00, 8'h11, 8'h11};
        vecs[11] = '{0, 1, 1, 8'hAA, 1, 2, 8'hBB, 8'h00, 8'h00};
        vecs[12] = '{0, 0, 1, 8'h00, 0, 2, 8'h00, 8'hAA, 8'hBB};
        vecs[13] = '{1, 1, 1, 8'h77, 0, 2, 8'h00, 8'h00, 8'h00};
        vecs[14] = '{0, 0, 1, 8'h00, 0, 2, 8'h00, 8'h00, 8'h00};

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].we_a, vecs[i].addr_a, vecs[i].din_a,
                 vecs[i].we_b, vecs[i].addr_b, vecs[i].din_b);
            check($sformatf("vec%0d_a", i), data_out_a, vecs[i].exp_a);
            check($sformatf("vec%0d_b", i), data_out_b, vecs[i].exp_b);
        end

        // Back-to-back writes to one address: each cycle returns the
        // previous write, and the last write is visible afterwards.
        step(0, 1, 9, 8'h01, 0, 9, 8'h00);
        check("b2b_w1_a", data_out_a, 8'h00);
        check("b2b_w1_b", data_out_b, 8'h00);
        step(0, 1, 9, 8'h02, 0, 9, 8'h00);
        check("b2b_w2_a", data_out_a, 8'h01);
        check("b2b_w2_b", data_out_b, 8'h01);
        step(0, 0, 9, 8'h00, 1, 9, 8'h03);
        check("b2b_w3_a", data_out_a, 8'h02);
        step(0, 0, 9, 8'h00, 0, 9, 8'h00);
        check("b2b_rd_a", data_out_a, 8'h03);
        check("b2b_rd_b", data_out_b, 8'h03);

        // Randomized run against the array model, starting from reset
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        step(1, 0, 0, 8'h00, 0, 0, 8'h00);
        check("rnd_reset_a", data_out_a, 8'h00);
        check("rnd_reset_b", data_out_b, 8'h00);

        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 39) == 0);
            wa = $urandom_range(0, 1);
            wb = $urandom_range(0, 1);
            // Narrow address range half the time to force collisions.
            if ($urandom_range(0, 1) == 1) begin
                aa = AW'($urandom_range(0, 2));
                ab = AW'($urandom_range(0, 2));
            end else begin
                aa = AW'($urandom_range(0, DEPTH - 1));
                ab = AW'($urandom_range(0, DEPTH - 1));
            end
            da = DW'($urandom);
            db = DW'($urandom);

            if (r) begin
                exp_a = '0;
                exp_b = '0;
                for (int k = 0; k < DEPTH; k++) model[k] = '0;
            end else begin
                exp_a = model[aa];
                exp_b = model[ab];
                if (wa && wb && aa == ab) begin
                    model[aa] = da;
                end else begin
                    if (wa) model[aa] = da;
                    if (wb) model[ab] = db;
                end
            end

            step(r, wa, aa, da, wb, ab, db);
            check($sformatf("rnd%0d_a", n), data_out_a, exp_a);
            check($sformatf("rnd%0d_b", n), data_out_b, exp_b);
        end

        // Final sweep: every word read back through both ports
        we_a = 1'b0;
        we_b = 1'b0;
        rst  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, AW'(i), 8'h00, 0, AW'(DEPTH - 1 - i), 8'h00);
            check($sformatf("sweep%0d_a", i), data_out_a, model[i]);
            check($sformatf("sweep%0d_b", i), data_out_b, model[DEPTH - 1 - i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_dual_port_ram

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
True dual-port synchronous RAM with two independent read/write ports (A and B) sharing one storage array and one clock. Each port has its own address, write data, write enable and registered read data. It is a generic on-chip buffer/scratchpad for datapaths that need concurrent access from two agents.

Parameters:
DATA_WIDTH, 8, width of each memory word and of the data ports.
ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH words (16 by default).

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
addr_a  input  ADDR_WIDTH  port A word address.
data_in_a  input  DATA_WIDTH  port A write data.
we_a  input  1  port A write enable (1 = write, 0 = read).
data_out_a  output  DATA_WIDTH  port A registered read data.
addr_b  input  ADDR_WIDTH  port B word address.
data_in_b  input  DATA_WIDTH  port B write data.
we_b  input  1  port B write enable.
data_out_b  output  DATA_WIDTH  port B registered read data.

Behaviour:
- All operations occur on the rising edge of clk; no combinational path from inputs to outputs.
- Reset: when rst=1 at a rising edge, data_out_a and data_out_b become 0 and every memory word becomes 0. Writes presented in that cycle are ignored. Reset takes priority over all other activity.
- Read: on every non-reset edge, each port registers mem[addr_x] into data_out_x. Latency is 1 cycle: the address is sampled at edge N and the data is visible after edge N.
- Write: if we_x=1 at a non-reset edge, mem[addr_x] <= data_in_x.
- Read-during-write on the same port is read-first: data_out_x gets the word's old contents, and the new value is readable from the next edge.
- Cross-port read while the other port writes the same address is also read-first: the reader gets the old value.
- Simultaneous writes by both ports to the same address: port A wins, so mem gets data_in_a. Both outputs return the old value that cycle.
- Simultaneous writes to different addresses both complete.
- Outputs hold their last registered value; they are refreshed every cycle whether or not a write occurs.
- Addresses always fall in range (depth = 2**ADDR_WIDTH), so there is no wrap-around or out-of-range case.
- Memory contents before the first reset are undefined (X in simulation).

Decomposition:
- Package dual_port_ram_pkg: default DATA_WIDTH/ADDR_WIDTH constants and a word typedef (logic [DATA_WIDTH-1:0]).
- No sub-module required. Optionally factor a single-port output-register stage (ram_port_reg) instantiated twice; the storage array and write arbitration stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles, deassert -> data_out_a = data_out_b = 00; reading addr 4 on both ports the next cycle returns 00.
- Port A write/read: addr_a=4, data_in_a=A5, we_a=1 for one cycle, then we_a=0 -> data_out_a = A5 one cycle after the read edge; port B reading addr 4 also returns A5.
- Port B overwrite: addr_b=4, data_in_b=5A, we_b=1 for one cycle, then we_b=0 -> port A read of addr 4 returns 5A one cycle later.
- Read-first: addr 4 holds 5A; port A writes 3C to addr 4 with we_a=1 -> data_out_a = 5A that cycle and 3C on the next read; port B reading addr 4 in the write cycle also returns 5A.
- Write collision: both ports write addr 7 in the same cycle (A=11, B=22) -> a subsequent read of addr 7 on either port returns 11.
- Independent writes plus mid-operation reset: A writes addr 1=AA and B writes addr 2=BB in the same cycle -> reads return AA and BB. Then assert rst in a cycle with we_a=1 -> that write is dropped, both outputs become 00, and addr 1 reads 00.
